// File: rtl/tl_get_fragment_ctrl_if.sv
// Bundle of the hold/repeat buffer dequeue side and the fragment output channel.
// The master modport is the fragment controller's view; slave is the environment.
interface tl_get_fragment_ctrl_if #(
    parameter int MAX_SIZE = 6,
    parameter int ADDR_W   = 32,
    parameter int SOURCE_W = 4
);
    localparam int CNT_W = (MAX_SIZE >= 14) ? 1 : 15 - MAX_SIZE;

    logic                rep_deq_valid;
    logic                rep_deq_ready;
    logic [2:0]          rep_deq_opcode;
    logic [3:0]          rep_deq_size;
    logic [SOURCE_W-1:0] rep_deq_source;
    logic [ADDR_W-1:0]   rep_deq_address;
    logic                rep_repeat;
    logic                out_valid;
    logic                out_ready;
    logic [2:0]          out_opcode;
    logic [3:0]          out_size;
    logic [SOURCE_W-1:0] out_source;
    logic [ADDR_W-1:0]   out_address;
    logic                out_last;
    logic [CNT_W-1:0]    out_frag;

    modport master (
        input  rep_deq_valid, rep_deq_opcode, rep_deq_size, rep_deq_source, rep_deq_address,
        input  out_ready,
        output rep_deq_ready, rep_repeat,
        output out_valid, out_opcode, out_size, out_source, out_address, out_last, out_frag
    );

    modport slave (
        output rep_deq_valid, rep_deq_opcode, rep_deq_size, rep_deq_source, rep_deq_address,
        output out_ready,
        input  rep_deq_ready, rep_repeat,
        input  out_valid, out_opcode, out_size, out_source, out_address, out_last, out_frag
    );
endinterface

// File: rtl/tl_get_fragment_ctrl.sv
// Splits an oversized Get held in a repeat buffer into MAX_SIZE-aligned fragments,
// driving the buffer's repeat input until the final fragment fires.
module tl_get_fragment_ctrl #(
    parameter int MAX_SIZE = 6,
    parameter int ADDR_W   = 32,
    parameter int SOURCE_W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    tl_get_fragment_ctrl_if.master   bus,
    output logic                     err_sticky
);
    localparam int CNT_W = (MAX_SIZE >= 14) ? 1 : 15 - MAX_SIZE;
    localparam logic [2:0] OP_GET = 3'd4;

    typedef enum logic {IDLE, BURST} state_t;

    logic [CNT_W-1:0]    cnt_reg;
    logic [2:0]          opcode_lat_reg;
    logic [3:0]          size_lat_reg;
    logic [SOURCE_W-1:0] source_lat_reg;
    logic [ADDR_W-1:0]   address_lat_reg;
    logic                err_reg;

    state_t              state;
    logic                frag;
    logic                fire;
    logic                last;
    logic                mismatch;
    logic [3:0]          shift;
    logic [15:0]         span;
    logic [CNT_W-1:0]    last_idx;

    assign state = (cnt_reg == '0) ? IDLE : BURST;

    always_comb begin
        frag     = (bus.rep_deq_opcode == OP_GET) && (bus.rep_deq_size > 4'(MAX_SIZE));
        shift    = frag ? (bus.rep_deq_size - 4'(MAX_SIZE)) : 4'd0;
        // span is at most 2^15, so 16 bits hold it; the index of the last fragment fits CNT_W
        span     = 16'd1 << shift;
        last_idx = CNT_W'(span - 16'd1);
        last     = (cnt_reg == last_idx);
        fire     = bus.rep_deq_valid & bus.out_ready;
        mismatch = (bus.rep_deq_opcode  != opcode_lat_reg)  ||
                   (bus.rep_deq_size    != size_lat_reg)    ||
                   (bus.rep_deq_source  != source_lat_reg)  ||
                   (bus.rep_deq_address != address_lat_reg);
    end

    assign bus.out_valid     = bus.rep_deq_valid;
    assign bus.rep_deq_ready = bus.out_ready;
    assign bus.out_opcode    = bus.rep_deq_opcode;
    assign bus.out_source    = bus.rep_deq_source;
    assign bus.out_size      = frag ? 4'(MAX_SIZE) : bus.rep_deq_size;
    assign bus.out_address   = bus.rep_deq_address + (ADDR_W'(cnt_reg) << MAX_SIZE);
    assign bus.out_frag      = cnt_reg;
    assign bus.out_last      = last;
    assign bus.rep_repeat    = bus.rep_deq_valid & frag & ~last;
    assign err_sticky        = err_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reg         <= '0;
            err_reg         <= 1'b0;
            opcode_lat_reg  <= '0;
            size_lat_reg    <= '0;
            source_lat_reg  <= '0;
            address_lat_reg <= '0;
        end else begin
            if (fire) begin
                cnt_reg <= last ? '0 : cnt_reg + 1'b1;
            end
            if (fire && frag && state == IDLE) begin
                opcode_lat_reg  <= bus.rep_deq_opcode;
                size_lat_reg    <= bus.rep_deq_size;
                source_lat_reg  <= bus.rep_deq_source;
                address_lat_reg <= bus.rep_deq_address;
            end
            // The buffer must keep presenting the same request for the whole burst
            if (state == BURST && (!bus.rep_deq_valid || mismatch)) begin
                err_reg <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tl_get_fragment_ctrl.sv
// Directed bench for tl_get_fragment_ctrl with MAX_SIZE=6: fragmentation,
// backpressure, pass-through, back-to-back, reset mid-burst and protocol errors.
module tb_tl_get_fragment_ctrl;
    logic clock;
    logic reset;
    logic err_sticky;
    int   tests;
    int   fails;

    tl_get_fragment_ctrl_if #(.MAX_SIZE(6), .ADDR_W(32), .SOURCE_W(4)) bus ();

    tl_get_fragment_ctrl #(.MAX_SIZE(6), .ADDR_W(32), .SOURCE_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .err_sticky (err_sticky)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src,
                         input logic [31:0] addr);
        bus.rep_deq_valid   = 1'b1;
        bus.rep_deq_opcode  = op;
        bus.rep_deq_size    = sz;
        bus.rep_deq_source  = src;
        bus.rep_deq_address = addr;
    endtask

    // Checks the presented fragment mid-cycle, then advances to the next falling edge
    task automatic expect_frag(input string tag, input logic [31:0] addr, input logic [3:0] sz,
                               input int idx, input logic rep, input logic lst);
        #1;
        check({tag, ".valid"}, 64'(bus.out_valid), 64'(1));
        check({tag, ".addr"},  64'(bus.out_address), 64'(addr));
        check({tag, ".size"},  64'(bus.out_size), 64'(sz));
        check({tag, ".frag"},  64'(bus.out_frag), 64'(idx));
        check({tag, ".repeat"}, 64'(bus.rep_repeat), 64'(rep));
        check({tag, ".last"},  64'(bus.out_last), 64'(lst));
        @(negedge clock);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.rep_deq_valid   = 1'b0;
        bus.rep_deq_opcode  = 3'd0;
        bus.rep_deq_size    = 4'd0;
        bus.rep_deq_source  = 4'd0;
        bus.rep_deq_address = 32'd0;
        bus.out_ready       = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check("rst.repeat", 64'(bus.rep_repeat), 64'(0));
        check("rst.frag",   64'(bus.out_frag), 64'(0));
        check("rst.err",    64'(err_sticky), 64'(0));
        check("rst.valid",  64'(bus.out_valid), 64'(0));
        @(negedge clock);
        reset = 1'b0;

        // 1: Get size 8 -> four 64-byte fragments
        drive(3'd4, 4'd8, 4'd3, 32'h1000);
        expect_frag("t1f0", 32'h1000, 4'd6, 0, 1'b1, 1'b0);
        expect_frag("t1f1", 32'h1040, 4'd6, 1, 1'b1, 1'b0);
        expect_frag("t1f2", 32'h1080, 4'd6, 2, 1'b1, 1'b0);
        expect_frag("t1f3", 32'h10C0, 4'd6, 3, 1'b0, 1'b1);
        bus.rep_deq_valid = 1'b0;
        #1;
        check("t1.cnt_idle", 64'(bus.out_frag), 64'(0));
        check("t1.valid_low", 64'(bus.out_valid), 64'(0));
        @(negedge clock);

        // 2: stall three cycles on fragment 1
        drive(3'd4, 4'd8, 4'd3, 32'h1000);
        expect_frag("t2f0", 32'h1000, 4'd6, 0, 1'b1, 1'b0);
        bus.out_ready = 1'b0;
        #1;
        check("t2.deq_ready", 64'(bus.rep_deq_ready), 64'(0));
        expect_frag("t2s0", 32'h1040, 4'd6, 1, 1'b1, 1'b0);
        expect_frag("t2s1", 32'h1040, 4'd6, 1, 1'b1, 1'b0);
        expect_frag("t2s2", 32'h1040, 4'd6, 1, 1'b1, 1'b0);
        bus.out_ready = 1'b1;
        expect_frag("t2f1", 32'h1040, 4'd6, 1, 1'b1, 1'b0);
        expect_frag("t2f2", 32'h1080, 4'd6, 2, 1'b1, 1'b0);
        expect_frag("t2f3", 32'h10C0, 4'd6, 3, 1'b0, 1'b1);

        // 3: small Get and PutFull pass through
        drive(3'd4, 4'd4, 4'd2, 32'h2008);
        expect_frag("t3get", 32'h2008, 4'd4, 0, 1'b0, 1'b1);
        drive(3'd0, 4'd8, 4'd2, 32'h3000);
        #1;
        check("t3put.opcode", 64'(bus.out_opcode), 64'(0));
        expect_frag("t3put", 32'h3000, 4'd8, 0, 1'b0, 1'b1);

        // 4: back-to-back requests with no bubble
        drive(3'd4, 4'd7, 4'd1, 32'h0);
        expect_frag("t4f0", 32'h0, 4'd6, 0, 1'b1, 1'b0);
        expect_frag("t4f1", 32'h40, 4'd6, 1, 1'b0, 1'b1);
        drive(3'd4, 4'd6, 4'd1, 32'h300);
        expect_frag("t4b", 32'h300, 4'd6, 0, 1'b0, 1'b1);
        bus.rep_deq_valid = 1'b0;
        #1;
        check("t4.err", 64'(err_sticky), 64'(0));
        @(negedge clock);

        // 5: reset in the middle of a size-9 burst
        drive(3'd4, 4'd9, 4'd4, 32'h0);
        expect_frag("t5f0", 32'h0, 4'd6, 0, 1'b1, 1'b0);
        expect_frag("t5f1", 32'h40, 4'd6, 1, 1'b1, 1'b0);
        expect_frag("t5f2", 32'h80, 4'd6, 2, 1'b1, 1'b0);
        reset = 1'b1;
        bus.rep_deq_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("t5.frag", 64'(bus.out_frag), 64'(0));
        check("t5.repeat", 64'(bus.rep_repeat), 64'(0));
        check("t5.err", 64'(err_sticky), 64'(0));
        drive(3'd4, 4'd7, 4'd4, 32'h500);
        expect_frag("t5n0", 32'h500, 4'd6, 0, 1'b1, 1'b0);
        expect_frag("t5n1", 32'h540, 4'd6, 1, 1'b0, 1'b1);
        bus.rep_deq_valid = 1'b0;
        @(negedge clock);

        // 6: source changes mid-burst
        drive(3'd4, 4'd8, 4'd3, 32'h1000);
        expect_frag("t6f0", 32'h1000, 4'd6, 0, 1'b1, 1'b0);
        expect_frag("t6f1", 32'h1040, 4'd6, 1, 1'b1, 1'b0);
        #1;
        check("t6.err_before", 64'(err_sticky), 64'(0));
        bus.rep_deq_source = 4'd5;
        check("t6.source", 64'(bus.out_source), 64'(5));
        expect_frag("t6f2", 32'h1080, 4'd6, 2, 1'b1, 1'b0);
        #1;
        check("t6.err_set", 64'(err_sticky), 64'(1));
        expect_frag("t6f3", 32'h10C0, 4'd6, 3, 1'b0, 1'b1);
        bus.rep_deq_valid = 1'b0;
        @(negedge clock);
        #1;
        check("t6.idle_frag", 64'(bus.out_frag), 64'(0));
        check("t6.err_hold", 64'(err_sticky), 64'(1));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("t6.err_clear", 64'(err_sticky), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tl_get_fragment_ctrl.md
Name: tl_get_fragment_ctrl

Overview:
Sequencer that drives the repeat input of a single-entry TileLink-style hold/repeat buffer so one oversized Get becomes a train of MAX_SIZE-aligned fragments. It sits on the buffer's dequeue side and rewrites size and address per fragment. It also produces the repeat strobe and per-fragment last/index sideband for the response reassembly logic. Other opcodes and small Gets pass through untouched.

Parameters:
MAX_SIZE, 6, log2 of largest fragment in bytes (legal 0..14)
ADDR_W, 32, address width
SOURCE_W, 4, source ID width
CNT_W, 15-MAX_SIZE (derived, min 1), fragment counter width

Ports:
clock  in  1  sole clock
reset  in  1  synchronous, active-high
rep_deq_valid  in  1  buffer dequeue valid
rep_deq_ready  out  1  buffer dequeue ready
rep_deq_opcode  in  3  held request opcode
rep_deq_size  in  4  held request log2 size
rep_deq_source  in  SOURCE_W  held request source
rep_deq_address  in  ADDR_W  held request base address
rep_repeat  out  1  to buffer repeat input
out_valid  out  1  fragment valid
out_ready  in  1  downstream ready
out_opcode  out  3  equals rep_deq_opcode
out_size  out  4  fragment log2 size
out_source  out  SOURCE_W  equals rep_deq_source
out_address  out  ADDR_W  fragment address
out_last  out  1  final fragment of request
out_frag  out  CNT_W  fragment index, 0-based
err_sticky  out  1  protocol error seen since reset

Behaviour:
- Handshake is combinational pass-through: out_valid = rep_deq_valid; rep_deq_ready = out_ready; fire = out_valid & out_ready. No added latency.
- frag = (rep_deq_opcode==4 && rep_deq_size>MAX_SIZE).
- total = frag ? 2^(rep_deq_size-MAX_SIZE) : 1.
- Registers: cnt (CNT_W, reset 0); err_sticky (reset 0).
- State: IDLE when cnt==0, BURST when cnt!=0. No other state.
- out_size = frag ? MAX_SIZE : rep_deq_size.
- out_address = rep_deq_address + (cnt << MAX_SIZE), truncated to ADDR_W. When frag=0, cnt is 0, so the address passes through.
- out_frag = cnt.
- out_last = (cnt == total-1).
- rep_repeat = rep_deq_valid & frag & ~out_last. It is asserted on the accept cycle and on every non-final fragment, so the buffer holds the request until the final fragment fires.
- Counter update on fire:
  - If out_last: cnt <= 0 (return to IDLE).
  - Else: cnt <= cnt+1.
  - No fire: cnt holds. All outputs stay stable under backpressure because the buffer holds its fields.
- Back-to-back: the final fragment of request N and the first fragment of request N+1 may fire on consecutive cycles with no bubble.
- Protocol checks in BURST, each sets err_sticky (cleared only by reset):
  - rep_deq_valid==0.
  - opcode, size, source or address differ from the values latched when the burst started. Latch opcode/size/source/address on the first fire of a fragmented request.
  - The controller keeps sequencing on its counter regardless.
- Size 15 with MAX_SIZE=0 gives total=2^15, which must fit in CNT_W=15. Counter wrap cannot occur because last is detected first.
- Reset mid-burst: cnt->0 and err_sticky->0 on the next edge. The companion buffer is reset on the same reset, so no stale repeat survives.
- Reset values: rep_repeat=0, out_frag=0, err_sticky=0. Other outputs are combinational from inputs, with out_valid=0 when rep_deq_valid=0.

Test Plan:
1. MAX_SIZE=6, Get size 8, addr 0x1000, src 3, out_ready=1: 4 fires, in order:
   - addresses 0x1000, 0x1040, 0x1080, 0x10C0
   - out_size 6 throughout
   - out_frag 0..3
   - rep_repeat 1,1,1,0
   - out_last only on the 4th
   - cnt back to 0
2. Same Get with out_ready low 3 cycles after fragment 1: out_address holds 0x1040, out_frag holds 1 and rep_repeat holds 1 while stalled; the sequence then completes unchanged.
3. Get size 4 addr 0x2008: one fire, size 4, address 0x2008, last=1, repeat=0. PutFull (opcode 0) size 8: one fire, size 8, repeat=0.
4. Get size 7 at 0x0 followed immediately by Get size 6 at 0x300: fires at 0x0, 0x40, then 0x300 on three consecutive cycles with no idle cycle.
5. Get size 9 and reset asserted after fragment 2: the cycle after reset, out_frag=0 and rep_repeat=0; a new Get size 7 produces fragments 0 and 1 correctly.
6. Get size 8 with rep_deq_source changed from 3 to 5 before fragment 2: err_sticky=1 the next cycle, the burst still ends after 4 fires, and err_sticky stays 1 until reset.
